// File: rtl/bus_master_if.sv
// Bus master interface: turns one CPU load/store into a request/grant/strobe/ready bus cycle.
// Optional ready timeout abort is enabled by defining BUS_TIMEOUT_EN.
module bus_master_if #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        cpu_req,
   input  logic        cpu_rw,
   input  logic [29:0] cpu_addr,
   input  logic [31:0] cpu_wr_data,
   output logic [31:0] cpu_rd_data,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        bus_req_,
   input  logic        bus_grnt_,
   output logic [29:0] bus_addr,
   output logic        bus_as_,
   output logic        bus_rw,
   output logic [31:0] bus_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy_
);

   localparam logic READ = 1'b1;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_WAIT} state_t;

   state_t      state, state_nx;
   logic        bus_req_nx, bus_as_nx, bus_rw_nx, cpu_done_nx;
   logic [29:0] bus_addr_nx;
   logic [31:0] bus_wr_data_nx, cpu_rd_data_nx;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt, to_cnt_nx;
   logic       cpu_err_nx;
`else
   assign cpu_err = 1'b0;
`endif

   assign cpu_busy = (state != ST_IDLE);

   always_comb begin
      state_nx       = state;
      bus_req_nx     = bus_req_;
      bus_as_nx      = 1'b1;   // strobe is only ever low for the single ACCESS cycle
      bus_rw_nx      = bus_rw;
      bus_addr_nx    = bus_addr;
      bus_wr_data_nx = bus_wr_data;
      cpu_rd_data_nx = cpu_rd_data;
      cpu_done_nx    = 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_nx      = to_cnt;
      cpu_err_nx     = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (cpu_req) begin
               bus_addr_nx    = cpu_addr;
               bus_rw_nx      = cpu_rw;
               bus_wr_data_nx = cpu_wr_data;
               bus_req_nx     = 1'b0;
               state_nx       = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!bus_grnt_) begin
               bus_as_nx = 1'b0;
               state_nx  = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
               to_cnt_nx = 8'd0;
`endif
            end
         end
         ST_ACCESS, ST_WAIT: begin
            if (!bus_rdy_) begin
               state_nx    = ST_IDLE;
               bus_req_nx  = 1'b1;
               cpu_done_nx = 1'b1;
               if (bus_rw == READ) cpu_rd_data_nx = bus_rd_data;
            end else begin
               state_nx = ST_WAIT;
`ifdef BUS_TIMEOUT_EN
               to_cnt_nx = to_cnt + 8'd1;
               if (to_cnt == TO_LAST) begin
                  state_nx       = ST_IDLE;
                  bus_req_nx     = 1'b1;
                  cpu_done_nx    = 1'b1;
                  cpu_err_nx     = 1'b1;
                  cpu_rd_data_nx = 32'd0;
               end
`endif
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state       <= ST_IDLE;
         bus_req_    <= 1'b1;
         bus_as_     <= 1'b1;
         bus_rw      <= READ;
         bus_addr    <= 30'd0;
         bus_wr_data <= 32'd0;
         cpu_rd_data <= 32'd0;
         cpu_done    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cpu_err     <= 1'b0;
         to_cnt      <= 8'd0;
`endif
      end else begin
         state       <= state_nx;
         bus_req_    <= bus_req_nx;
         bus_as_     <= bus_as_nx;
         bus_rw      <= bus_rw_nx;
         bus_addr    <= bus_addr_nx;
         bus_wr_data <= bus_wr_data_nx;
         cpu_rd_data <= cpu_rd_data_nx;
         cpu_done    <= cpu_done_nx;
`ifdef BUS_TIMEOUT_EN
         cpu_err     <= cpu_err_nx;
         to_cnt      <= to_cnt_nx;
`endif
      end
   end

endmodule

// File: doc/bus_master_if.md
# bus_master_if

Bus master interface unit that turns a single-word CPU-side load/store request into a full bus transaction: request the bus, wait for grant, issue the address strobe, wait for the addressed slave's ready, and return read data. It sits between a CPU memory stage and the shared bus. It drives request, address and write signals toward the arbiter, master mux and address decoder. It consumes the read data and ready returned through the slave read mux.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles without `bus_rdy_` before abort (only with `BUS_TIMEOUT_EN`); legal range 1..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_` in 1: synchronous, active-low reset.
- `cpu_req` in 1: active-high request; sampled only in IDLE.
- `cpu_rw` in 1: `READ` (1) or `WRITE` (0).
- `cpu_addr` in 30: `WordAddrBus` word address.
- `cpu_wr_data` in 32: `WordDataBus` store data.
- `cpu_rd_data` out 32: load result; holds until next read completes.
- `cpu_busy` out 1: high while a transaction is in progress (state != IDLE).
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_done`; 1 = timeout abort.
- `bus_req_` out 1: active-low bus request to arbiter.
- `bus_grnt_` in 1: active-low grant.
- `bus_addr` out 30: transaction address.
- `bus_as_` out 1: active-low address strobe.
- `bus_rw` out 1: transaction direction.
- `bus_wr_data` out 32: write data.
- `bus_rd_data` in 32: read data from slave read mux.
- `bus_rdy_` in 1: active-low ready from slave read mux.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `bus_req_`=1, `bus_as_`=1, `bus_rw`=`READ`
  - `bus_addr`=0, `bus_wr_data`=0
  - `cpu_rd_data`=0, `cpu_done`=0, `cpu_err`=0
  - timeout counter=0
- FSM has four states.
- **IDLE**
  - `cpu_req`=1: latch `cpu_addr`/`cpu_rw`/`cpu_wr_data` into the `bus_*` registers, drive `bus_req_`=0, go to REQ.
- **REQ**
  - `bus_grnt_`=0: drive `bus_as_`=0, go to ACCESS.
  - Otherwise hold.
- **ACCESS**
  - One cycle with `bus_as_` low; `bus_as_` returns high next cycle.
  - Sample `bus_rdy_` this cycle. If low, complete; else go to WAIT.
- **WAIT**
  - Sample `bus_rdy_` every cycle; complete when it is low.
- **Completion**
  - Next state IDLE.
  - `bus_req_`←1.
  - `cpu_done`←1 for exactly one cycle; `cpu_err`←0.
  - If read, `cpu_rd_data`←`bus_rd_data`. If write, `cpu_rd_data` is unchanged.
- `cpu_req` outside IDLE is ignored; no queueing.
- `bus_grnt_` is ignored outside REQ; a grant drop in ACCESS/WAIT does not abort.
- A reset asserted in any state forces IDLE and reset values on the next edge; any in-flight transaction is abandoned.

## Timing
- `bus_req_` falls 1 cycle after `cpu_req` is accepted.
- Zero-wait slave with grant present in the first REQ cycle:
  - accept at edge T
  - REQ at T+1, `bus_as_` low at T+2 (ACCESS)
  - `cpu_done` and `bus_req_` high at T+3
- Each extra cycle of `bus_rdy_` high adds 1 cycle. Each cycle of grant delay adds 1 cycle.
- In the `cpu_done` cycle the FSM is IDLE and may accept a new `cpu_req`. Back-to-back issue with zero gap is required.
- `cpu_busy` is high from T+1 through the last ACCESS/WAIT cycle.
- `bus_addr`/`bus_rw`/`bus_wr_data` are stable from REQ until IDLE is re-entered.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on ACCESS entry and increments each ACCESS/WAIT cycle with `bus_rdy_` high.
  - When it reaches `TIMEOUT_CYCLES`, abort:
    - `bus_req_`←1, `bus_as_` stays high, state←IDLE
    - `cpu_done`←1 with `cpu_err`←1, `cpu_rd_data`←0
  - `bus_rdy_` low in the same cycle as the limit wins: normal completion, `cpu_err`=0.
- `BUS_TIMEOUT_EN` undefined:
  - No counter; WAIT holds indefinitely.
  - `cpu_err` is constant 0; `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset held 3 cycles during WAIT → next cycle: IDLE, `bus_req_`=1, `bus_as_`=1, `cpu_done`=0, `cpu_rd_data`=0.
- Read addr 0x0000_0010, grant immediate, `bus_rdy_` low in ACCESS, `bus_rd_data`=0xDEAD_BEEF → `bus_as_` low exactly 1 cycle; `cpu_done` 3 cycles after accept; `cpu_rd_data`=0xDEAD_BEEF.
- Write addr 0x1000_0004, data 0x1234_5678, grant delayed 4 cycles, `bus_rdy_` after 2 WAIT cycles → `bus_req_` low 8 cycles; `bus_addr`/`bus_wr_data` stable throughout; `cpu_rd_data` unchanged.
- Two back-to-back reads with `cpu_req` held high → second `bus_req_` falls the cycle after the first `cpu_done`; no request lost; `cpu_rd_data` updates twice.
- `cpu_req` pulsed during WAIT → ignored; exactly one `cpu_done`.
- With `BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `bus_rdy_` never low → `cpu_done`=1 with `cpu_err`=1 after 4 ACCESS/WAIT cycles, `bus_req_` released. Repeat with `bus_rdy_` low on the 4th cycle → `cpu_err`=0.
